// File: rtl/sanity_timer.sv
// DELQA sanity timer: counts host inactivity in quarter-second ticks and requests a BDCOK pulse on expiry.
// Optional sticky expiry status (exp_o/clr_i) is enabled by defining SANITY_STATUS_EN.
module sanity_timer #(
  parameter int CLK_DIV  = 625000,
  parameter int GEN_HOLD = 16
) (
  input  logic       clock_i,
  input  logic       rstn_i,
  input  logic       en_i,
  input  logic [2:0] sel_i,
  input  logic       kick_i,
`ifdef SANITY_STATUS_EN
  input  logic       clr_i,
  output logic       exp_o,
`endif
  output logic       gen_o,
  output logic       busy_o
);

  localparam logic [19:0] PCNT_MAX = 20'(CLK_DIV - 1);
  localparam logic [4:0]  HCNT_MAX = 5'(GEN_HOLD - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIRE} state_e;

  state_e      state_q, state_d;
  logic [19:0] pcnt_q, pcnt_d;
  logic [13:0] qcnt_q, qcnt_d;
  logic [13:0] lim_q, lim_d;
  logic [4:0]  hcnt_q, hcnt_d;
  logic        gen_q, gen_d;
  logic        busy_q, busy_d;
  logic        tick;

  // Timeout in quarter-second ticks; the upper codes are minute multiples, not powers of four.
  function automatic logic [13:0] sel_limit(input logic [2:0] sel);
    case (sel)
      3'd0:    sel_limit = 14'd1;
      3'd1:    sel_limit = 14'd4;
      3'd2:    sel_limit = 14'd16;
      3'd3:    sel_limit = 14'd64;
      3'd4:    sel_limit = 14'd240;
      3'd5:    sel_limit = 14'd960;
      3'd6:    sel_limit = 14'd3840;
      default: sel_limit = 14'd15360;
    endcase
  endfunction

  assign tick = (pcnt_q == PCNT_MAX);

  always_ff @(posedge clock_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      pcnt_q  <= '0;
      qcnt_q  <= '0;
      lim_q   <= 14'd1;
      hcnt_q  <= '0;
      gen_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      qcnt_q  <= qcnt_d;
      lim_q   <= lim_d;
      hcnt_q  <= hcnt_d;
      gen_q   <= gen_d;
      busy_q  <= busy_d;
    end
  end

  // A kick in RUN suppresses a coincident expiring tick.
  always_comb begin
    state_d = state_q;
    if (!en_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = RUN;
        RUN:  if (!kick_i && tick && (qcnt_q + 14'd1 == lim_q)) state_d = FIRE;
        FIRE: if (hcnt_q == HCNT_MAX) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    pcnt_d = '0;
    qcnt_d = '0;
    hcnt_d = '0;
    lim_d  = lim_q;
    gen_d  = 1'b0;
    busy_d = (state_d != IDLE);
    if (en_i) begin
      case (state_q)
        IDLE: lim_d = sel_limit(sel_i);
        RUN: begin
          if (kick_i) begin
            lim_d = sel_limit(sel_i);
          end else if (state_d == FIRE) begin
            gen_d = 1'b1;
          end else if (tick) begin
            qcnt_d = qcnt_q + 14'd1;
          end else begin
            pcnt_d = pcnt_q + 20'd1;
            qcnt_d = qcnt_q;
          end
        end
        FIRE: begin
          if (state_d == FIRE) begin
            gen_d  = 1'b1;
            hcnt_d = hcnt_q + 5'd1;
          end else begin
            lim_d = sel_limit(sel_i);
          end
        end
        default: lim_d = lim_q;
      endcase
    end
  end

  assign gen_o  = gen_q;
  assign busy_o = busy_q;

`ifdef SANITY_STATUS_EN
  logic exp_q, exp_d;

  // Entering FIRE beats a simultaneous clear.
  always_comb begin
    exp_d = exp_q;
    if (clr_i) exp_d = 1'b0;
    if (state_q == RUN && state_d == FIRE) exp_d = 1'b1;
  end

  always_ff @(posedge clock_i or negedge rstn_i) begin
    if (!rstn_i) exp_q <= 1'b0;
    else         exp_q <= exp_d;
  end

  assign exp_o = exp_q;
`endif

endmodule

// File: tb/tb_sanity_timer.sv
// Scoreboard bench for sanity_timer: expected gen_o pulses (rise cycle, width) are queued by the
// stimulus and checked by a monitor; status checks run when SANITY_STATUS_EN is defined.
module tb_sanity_timer;

  localparam int DIV  = 4;
  localparam int HOLD = 16;

  logic       clock = 1'b0;
  logic       rstn;
  logic       en;
  logic [2:0] sel;
  logic       kick;
  logic       gen;
  logic       busy;
`ifdef SANITY_STATUS_EN
  logic       clr;
  logic       expo;
`endif

  int cyc   = 0;
  int tests = 0;
  int fails = 0;
  int c, e, f, r;

  typedef struct {
    int rise;
    int width;
  } pulse_t;

  pulse_t sbq[$];
  pulse_t cur;
  logic   genPrev  = 1'b0;
  int     riseCyc  = 0;
  int     wantWidth = HOLD;

  sanity_timer #(
    .CLK_DIV (DIV),
    .GEN_HOLD(HOLD)
  ) dut (
    .clock_i(clock),
    .rstn_i (rstn),
    .en_i   (en),
    .sel_i  (sel),
    .kick_i (kick),
`ifdef SANITY_STATUS_EN
    .clr_i  (clr),
    .exp_o  (expo),
`endif
    .gen_o  (gen),
    .busy_o (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic applyStimulus(input logic enV, input logic [2:0] selV, input logic kickV);
    en   = enV;
    sel  = selV;
    kick = kickV;
  endtask

  task automatic checkOutput(input string name, input logic act, input logic req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %b, expected %b (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) @(negedge clock);
  endtask

  task automatic expectPulse(input int rise, input int width);
    pulse_t p;
    p.rise  = rise;
    p.width = width;
    sbq.push_back(p);
  endtask

  // Monitor: every gen_o rise pops one expected pulse; every fall checks its width.
  always @(negedge clock) begin
    if (gen === 1'b1 && !genPrev) begin
      tests++;
      riseCyc = cyc;
      if (sbq.size() == 0) begin
        fails++;
        wantWidth = HOLD;
        $display("[TB] FAIL unexpected_rise: gen_o rose at cycle %0d, no pulse expected", cyc);
      end else begin
        cur = sbq.pop_front();
        wantWidth = cur.width;
        if (cur.rise != cyc) begin
          fails++;
          $display("[TB] FAIL rise_time: gen_o rose at cycle %0d, expected %0d", cyc, cur.rise);
        end
      end
    end else if (gen !== 1'b1 && genPrev) begin
      tests++;
      if (cyc - riseCyc != wantWidth) begin
        fails++;
        $display("[TB] FAIL pulse_width: got %0d clocks, expected %0d", cyc - riseCyc, wantWidth);
      end
    end
    genPrev = (gen === 1'b1);
  end

  initial begin
    rstn = 1'b0;
    applyStimulus(1'b0, 3'd0, 1'b0);
`ifdef SANITY_STATUS_EN
    clr = 1'b0;
`endif
    #2;
    checkOutput("reset_gen", gen, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
`ifdef SANITY_STATUS_EN
    checkOutput("reset_exp", expo, 1'b0);
`endif
    @(negedge clock);
    rstn = 1'b1;
    @(negedge clock);
    checkOutput("idle_busy", busy, 1'b0);

    // sel=0, free running: rises every 4 clocks of RUN, 16 clocks high
    c = cyc;
    applyStimulus(1'b1, 3'd0, 1'b0);
    e = c + 1;
    expectPulse(e + 4, HOLD);
    expectPulse(e + 24, HOLD);
    expectPulse(e + 44, HOLD);
    waitUntil(e + 2);
    checkOutput("t1_run_busy", busy, 1'b1);
    checkOutput("t1_run_gen", gen, 1'b0);
    waitUntil(e + 61);
    applyStimulus(1'b0, 3'd0, 1'b0);
    @(negedge clock);
    checkOutput("t1_disable_busy", busy, 1'b0);

    // sel=1 (16 clocks), kicked every 10 clocks: never fires
    c = cyc;
    applyStimulus(1'b1, 3'd1, 1'b0);
    e = c + 1;
    for (int i = 1; i <= 6; i++) begin
      waitUntil(e + 10 * i - 1);
      kick = 1'b1;
      @(negedge clock);
      kick = 1'b0;
    end
    waitUntil(e + 70);
    checkOutput("t2_kicked_busy", busy, 1'b1);
    applyStimulus(1'b0, 3'd1, 1'b0);
    @(negedge clock);

    // Kick sampled on the expiring 4th tick: no fire, expiry 16 clocks after the kick
    c = cyc;
    applyStimulus(1'b1, 3'd1, 1'b0);
    e = c + 1;
    expectPulse(e + 32, HOLD);
    waitUntil(e + 15);
    kick = 1'b1;
    @(negedge clock);
    kick = 1'b0;
    checkOutput("t3_kick_beats_tick", gen, 1'b0);
    waitUntil(e + 49);
    applyStimulus(1'b0, 3'd1, 1'b0);
    @(negedge clock);
    checkOutput("t3_disable_busy", busy, 1'b0);

    // Enable dropped 5 clocks into FIRE, then a full-length timeout after re-enable
    c = cyc;
    applyStimulus(1'b1, 3'd0, 1'b0);
    e = c + 1;
    f = e + 4;
    expectPulse(f, 5);
    waitUntil(f + 4);
    en = 1'b0;
    @(negedge clock);
    checkOutput("t4_trunc_gen", gen, 1'b0);
    checkOutput("t4_trunc_busy", busy, 1'b0);
    waitUntil(f + 7);
    applyStimulus(1'b1, 3'd1, 1'b0);
    e = f + 8;
    expectPulse(e + 16, HOLD);
    waitUntil(e + 33);
    applyStimulus(1'b0, 3'd1, 1'b0);
    @(negedge clock);

    // Asynchronous reset mid-RUN, then RUN re-entered on the first edge after release
    c = cyc;
    applyStimulus(1'b1, 3'd2, 1'b0);
    e = c + 1;
    waitUntil(e + 20);
    checkOutput("t5_busy_before", busy, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("t5_async_gen", gen, 1'b0);
    checkOutput("t5_async_busy", busy, 1'b0);
    @(negedge clock);
    applyStimulus(1'b1, 3'd0, 1'b0);
    rstn = 1'b1;
    r = cyc;
    expectPulse(r + 5, HOLD);
    @(negedge clock);
    checkOutput("t5_rerun_busy", busy, 1'b1);
    waitUntil(r + 22);
    applyStimulus(1'b0, 3'd0, 1'b0);
    @(negedge clock);

`ifdef SANITY_STATUS_EN
    // Sticky status: set on FIRE entry, cleared by clr_i, set wins over coincident clear
    clr = 1'b1;
    @(negedge clock);
    clr = 1'b0;
    checkOutput("t6_clear_before", expo, 1'b0);
    c = cyc;
    applyStimulus(1'b1, 3'd0, 1'b0);
    e = c + 1;
    f = e + 4;
    expectPulse(f, HOLD);
    expectPulse(f + 20, HOLD);
    waitUntil(f - 1);
    checkOutput("t6_exp_pre_fire", expo, 1'b0);
    waitUntil(f);
    checkOutput("t6_exp_set", expo, 1'b1);
    waitUntil(f + 17);
    checkOutput("t6_exp_held_run", expo, 1'b1);
    clr = 1'b1;
    @(negedge clock);
    clr = 1'b0;
    checkOutput("t6_exp_cleared", expo, 1'b0);
    waitUntil(f + 19);
    clr = 1'b1;
    @(negedge clock);
    clr = 1'b0;
    checkOutput("t6_set_beats_clear", expo, 1'b1);
    waitUntil(f + 37);
    applyStimulus(1'b0, 3'd0, 1'b0);
    @(negedge clock);
`endif

    repeat (30) @(negedge clock);
    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("[TB] FAIL pending_pulses: %0d expected pulses never seen, required 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sanity_timer.md
Name: sanity_timer

Overview:
- Upstream companion of the BDCOK pulse generator, which it feeds through that block's generate input (gen_i).
- Implements the DELQA sanity timer countdown (EK-DELQA-UG-002 §3.6.6). Counts host inactivity in quarter-second ticks derived from the 2.5 MHz clock.
- On expiry, drives its generate output high for a fixed number of clocks so the downstream stage emits one ~4 ms negative BDCOK. Then re-arms.

Parameters:
- CLK_DIV, 625000, clocks per quarter-second tick (2.5 MHz / 4). Legal range 2..2^20.
- GEN_HOLD, 16, clocks gen_o stays high per expiry. Must exceed the downstream BDCOK limit (10) + 1.

Ports:
- clock_i  in  1  2.5 MHz clock.
- rstn_i  in  1  asynchronous active-low reset.
- en_i  in  1  timer enable (setup packet / jumper); level.
- sel_i  in  3  timeout select: 0=1/4s 1=1s 2=4s 3=16s 4=1min 5=4min 6=16min 7=64min.
- kick_i  in  1  one-clock pulse on host access; restarts the countdown.
- gen_o  out  1  expiry request to the BDCOK generator, active 1.
- busy_o  out  1  high while in RUN or FIRE.

Behaviour:
- Timeout limit in ticks, 14-bit: 1, 4, 16, 64, 240, 960, 3840, 15360 for sel 0..7.
- Internal registers:
  - 20-bit prescaler pcnt. tick = (pcnt == CLK_DIV-1); pcnt wraps to 0 on tick.
  - 14-bit tick counter qcnt.
  - latched limit lim.
  - 5-bit hold counter hcnt.
- Reset (async, rstn_i=0): state=IDLE, pcnt=qcnt=hcnt=0, lim=1, gen_o=0, busy_o=0.
- IDLE:
  - Counters held at 0.
  - en_i=1 → RUN. Same edge: lim latched from sel_i, pcnt=qcnt=0.
- RUN:
  - pcnt increments every clock.
  - On tick, qcnt increments.
  - On the edge where tick=1 and qcnt+1==lim: → FIRE, gen_o←1, hcnt←0.
  - Expiry latency: gen_o rises exactly lim*CLK_DIV clocks after the edge that entered RUN or sampled kick_i.
  - kick_i=1: pcnt=qcnt=0, lim re-latched from sel_i. Kick wins over a coincident expiring tick (no FIRE).
  - sel_i changes without a kick are ignored until the next kick or re-enable.
- FIRE:
  - gen_o=1, hcnt increments each clock.
  - When hcnt==GEN_HOLD-1: → RUN, gen_o←0, pcnt=qcnt=0, lim re-latched. gen_o is high for exactly GEN_HOLD clocks.
  - kick_i is ignored in FIRE. The pulse always completes unless en_i drops.
- en_i=0 in any state → IDLE on next edge: gen_o←0, all counters cleared. A truncated FIRE is acceptable; the downstream stage releases BDCOK when gen drops.
- busy_o = (state != IDLE), registered with state.
- No counter overflow: qcnt never exceeds lim-1, pcnt never exceeds CLK_DIV-1.

Optional Feature:
- Macro SANITY_STATUS_EN.
- Defined:
  - Adds port exp_o (out, 1): sticky, set on the edge entering FIRE.
  - Adds port clr_i (in, 1): clears exp_o on the next edge. Set wins over a simultaneous clear.
  - Reset value of exp_o is 0.
- Undefined: neither port exists; no status register; behaviour otherwise identical.

Test Plan:
- CLK_DIV=4, GEN_HOLD=16, en_i=1, sel_i=0, no kicks → gen_o rises 4 clocks after RUN entry, stays high 16 clocks, then rises again 4 clocks after falling.
- CLK_DIV=4, sel_i=1, kick_i pulsed every 10 clocks → gen_o never asserts (limit = 16 clocks).
- CLK_DIV=4, sel_i=1, kick_i on the exact edge of the 4th tick → no FIRE; next expiry 16 clocks after the kick.
- en_i dropped 5 clocks into FIRE → gen_o=0 and busy_o=0 next edge; re-enable gives a full-length timeout.
- rstn_i asserted mid-RUN (asynchronous, between edges) → gen_o=0 and busy_o=0 immediately; after release with en_i=1, RUN is re-entered on the first edge.
- SANITY_STATUS_EN defined, one expiry → exp_o=1 held through RUN. clr_i pulse → exp_o=0. clr_i coincident with FIRE entry → exp_o stays 1.
